// File: rtl/if_id_pipe.sv
// ---------------------------------------------------------------------------
// if_id_pipe
//   Elastic IF->ID pipeline register with a two-slot skid buffer. The main
//   slot drives the decode-side outputs. The skid slot catches the one
//   instruction that fetch may hand over in the same cycle decode stalls.
//   An EX misprediction flush kills both slots. It also drops whatever
//   fetch offers in that cycle.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  fetch-side handshake; in_ready comes from flops only
//   in_pc, in_inst, in_pred_pc, in_bht, in_br_detect
//                   fetched instruction and its prediction metadata
//   out_valid/ready decode-side handshake
//   out_pc, out_inst, out_pred_pc, out_bht, out_br_detect, out_is_rvc
//                   main-slot payload
//   flush           synchronous kill of all buffered instructions
//   occupancy       number of valid slots (0..2)
//   flush_count     saturating count of flush cycles that killed something
// ---------------------------------------------------------------------------
module if_id_pipe #(
  parameter int XLEN  = 32,
  parameter int BHT_W = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_inst,
  input  logic [XLEN-1:0]  in_pred_pc,
  input  logic [BHT_W-1:0] in_bht,
  input  logic             in_br_detect,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_inst,
  output logic [XLEN-1:0]  out_pred_pc,
  output logic [BHT_W-1:0] out_bht,
  output logic             out_br_detect,
  output logic             out_is_rvc,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] flush_count
);

  // Payload layout: {pc, inst, pred_pc, bht, br_detect, is_rvc}
  localparam int PW = 3 * XLEN + BHT_W + 2;

  localparam int OFF_RVC  = 0;
  localparam int OFF_BR   = 1;
  localparam int OFF_BHT  = 2;
  localparam int OFF_PRED = OFF_BHT + BHT_W;
  localparam int OFF_INST = OFF_PRED + XLEN;
  localparam int OFF_PC   = OFF_INST + XLEN;

  logic             r_main_valid;
  logic             r_skid_valid;
  logic [PW-1:0]    r_main_pay;
  logic [PW-1:0]    r_skid_pay;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_in_rvc;
  logic [PW-1:0]    w_in_pay;
  logic             w_accept;
  logic             w_emit;
  logic             w_kill;
  logic             w_cnt_sat;

  // RVC is decided once, from the raw encoding, when the instruction is accepted.
  assign w_in_rvc = (in_inst[1:0] != 2'b11);
  assign w_in_pay = {in_pc, in_inst, in_pred_pc, in_bht, in_br_detect, w_in_rvc};

  // in_ready depends only on the skid flop. This keeps decode's out_ready
  // off the fetch-side timing path.
  assign in_ready  = ~r_skid_valid;
  assign out_valid = r_main_valid & ~flush;

  assign w_accept  = in_valid & ~r_skid_valid & ~flush;
  assign w_emit    = out_valid & out_ready;
  assign w_kill    = flush & (r_main_valid | r_skid_valid);
  assign w_cnt_sat = &r_flush_cnt;

  // -------------------------------------------------------------------------
  // Slot valid bits
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid) begin
      // The skid slot is never valid while main is empty.
      r_main_valid <= w_accept;
    end else if (w_emit) begin
      if (r_skid_valid) begin
        r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= w_accept;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Payload registers. They are not cleared on flush, so stale data may remain.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_pay <= '0;
      r_skid_pay <= '0;
    end else if (!flush) begin
      if (!r_main_valid) begin
        if (w_accept) begin
          r_main_pay <= w_in_pay;
        end
      end else if (w_emit) begin
        if (r_skid_valid) begin
          r_main_pay <= r_skid_pay;
        end else if (w_accept) begin
          r_main_pay <= w_in_pay;
        end
      end else if (w_accept) begin
        r_skid_pay <= w_in_pay;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Flush counter: counts only flush cycles that killed something, and
  // saturates instead of wrapping.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt <= '0;
    end else if (w_kill && !w_cnt_sat) begin
      r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_pc        = r_main_pay[OFF_PC   +: XLEN];
  assign out_inst      = r_main_pay[OFF_INST +: XLEN];
  assign out_pred_pc   = r_main_pay[OFF_PRED +: XLEN];
  assign out_bht       = r_main_pay[OFF_BHT  +: BHT_W];
  assign out_br_detect = r_main_pay[OFF_BR];
  assign out_is_rvc    = r_main_pay[OFF_RVC];

  assign occupancy   = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
  assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_if_id_pipe.sv
module tb_if_id_pipe;

  // The bench uses a narrow flush counter so that saturation is reachable in a
  // short run. All-ones here is 4'hF.
  localparam int XLEN  = 32;
  localparam int BHT_W = 2;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pred;
    logic [1:0]  bht;
    logic        br;
    logic        rvc;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc = '0;
  logic [XLEN-1:0]  in_inst = '0;
  logic [XLEN-1:0]  in_pred_pc = '0;
  logic [BHT_W-1:0] in_bht = '0;
  logic             in_br_detect = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_inst;
  logic [XLEN-1:0]  out_pred_pc;
  logic [BHT_W-1:0] out_bht;
  logic             out_br_detect;
  logic             out_is_rvc;
  logic             flush = 1'b0;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] flush_count;

  int n_cmp = 0;
  int n_err = 0;
  vec_t exp_q[$];

  if_id_pipe #(.XLEN(XLEN), .BHT_W(BHT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_pred_pc(in_pred_pc),
    .in_bht(in_bht), .in_br_detect(in_br_detect),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_pred_pc(out_pred_pc),
    .out_bht(out_bht), .out_br_detect(out_br_detect), .out_is_rvc(out_is_rvc),
    .flush(flush), .occupancy(occupancy), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every emit must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_emit: got pc %0h, expected no instruction", out_pc);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        chk("emit_pc",   out_pc,        e.pc);
        chk("emit_inst", out_inst,      e.inst);
        chk("emit_pred", out_pred_pc,   e.pred);
        chk("emit_bht",  out_bht,       e.bht);
        chk("emit_br",   out_br_detect, e.br);
        chk("emit_rvc",  out_is_rvc,    e.rvc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_pc        = v.pc;
    in_inst      = v.inst;
    in_pred_pc   = v.pred;
    in_bht       = v.bht;
    in_br_detect = v.br;
  endtask

  function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] inst,
                              input logic [31:0] pred, input logic [1:0] bht,
                              input logic br, input logic rvc);
    vec_t v;
    v.pc = pc; v.inst = inst; v.pred = pred; v.bht = bht; v.br = br; v.rvc = rvc;
    return v;
  endfunction

  // Offer one instruction and hold it until the DUT accepts it.
  task automatic offer(input vec_t v);
    bit done;
    done = 1'b0;
    drive(v);
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        exp_q.push_back(v);
        done = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL offer_timeout: got no accept for pc %0h, expected accept within 50 cycles", v.pc);
    end
  endtask

  task automatic drain();
    int k;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      step();
      k++;
    end
    step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got time limit, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CNT_W-1:0] exp_cnt;
    vec_t v;
    vec_t meta[4];

    // ---------------- reset state ----------------
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready, 1);
    chk("rst_occ",       occupancy, 0);
    chk("rst_fcnt",      flush_count, 0);
    chk("rst_out_pc",    out_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---------------- 1: streaming ----------------
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = mk(32'(4 * i), 32'h0000_0013 | 32'(i << 7), 32'(4 * i + 4), 2'(i), 1'(i), 1'b0);
      drive(v);
      @(negedge clk);
      chk("stream_in_ready", in_ready, 1);
      chk("stream_occ_le1", (occupancy <= 2'd1), 1);
      if (i > 0) begin
        chk("stream_out_valid", out_valid, 1);
        chk("stream_out_pc", out_pc, 32'(4 * (i - 1)));
      end
      exp_q.push_back(v);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", out_valid, 1);
    chk("stream_last_pc", out_pc, 32'd28);
    drain();

    // ---------------- 2: stall / skid ----------------
    out_ready = 1'b0;
    step();
    v = mk(32'h100, 32'h0010_0093, 32'h104, 2'b01, 1'b0, 1'b0);
    drive(v);
    in_valid = 1'b1;
    @(negedge clk);
    chk("skid_ready0", in_ready, 1);
    exp_q.push_back(v);
    step();
    v = mk(32'h104, 32'h0020_0113, 32'h108, 2'b10, 1'b0, 1'b0);
    drive(v);
    @(negedge clk);
    chk("skid_ready1", in_ready, 1);
    chk("skid_occ1", occupancy, 1);
    chk("skid_head_pc", out_pc, 32'h100);
    exp_q.push_back(v);
    step();
    v = mk(32'h108, 32'h0030_0193, 32'h10c, 2'b11, 1'b1, 1'b0);
    drive(v);
    @(negedge clk);
    chk("skid_occ2", occupancy, 2);
    chk("skid_ready_low", in_ready, 0);
    step();
    @(negedge clk);
    chk("skid_hold_occ", occupancy, 2);
    chk("skid_hold_pc", out_pc, 32'h100);
    step();
    out_ready = 1'b1;
    offer(v);
    drain();

    // ---------------- 3: flush with both slots full ----------------
    out_ready = 1'b0;
    offer(mk(32'h180, 32'h0000_0013, 32'h184, 2'b00, 1'b0, 1'b0));
    offer(mk(32'h184, 32'h0000_0013, 32'h188, 2'b00, 1'b0, 1'b0));
    drive(mk(32'h200, 32'h0000_0013, 32'h204, 2'b00, 1'b0, 1'b0));
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    exp_q.delete();
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_occ", occupancy, 0);
    chk("flush_valid_after", out_valid, 0);
    chk("flush_cnt1", flush_count, 1);
    out_ready = 1'b1;
    repeat (3) step();

    // ---------------- 4: empty flush and saturation ----------------
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_empty_cnt", flush_count, 1);
    step();
    exp_cnt = 4'd1;
    for (int k = 0; k < 18; k++) begin
      out_ready = 1'b0;
      offer(mk(32'(32'h280 + 4 * k), 32'h0000_0013, 32'h0, 2'b00, 1'b0, 1'b0));
      flush = 1'b1;
      exp_q.delete();
      step();
      flush = 1'b0;
      exp_cnt = (exp_cnt == CNT_MAX) ? CNT_MAX : exp_cnt + 4'd1;
      @(negedge clk);
      chk("flush_sat_cnt", flush_count, exp_cnt);
      chk("flush_sat_occ", occupancy, 0);
      step();
    end

    // ---------------- 5: metadata and RVC ----------------
    meta[0] = mk(32'h400, 32'h0000_4501, 32'h40,   2'b11, 1'b1, 1'b1);
    meta[1] = mk(32'h402, 32'h00a0_0093, 32'h406,  2'b00, 1'b0, 1'b0);
    meta[2] = mk(32'h406, 32'h0000_8082, 32'h1234, 2'b01, 1'b1, 1'b1);
    meta[3] = mk(32'h408, 32'hffff_fffc, 32'h40c,  2'b10, 1'b0, 1'b1);
    out_ready = 1'b0;
    offer(meta[0]);
    @(negedge clk);
    chk("meta_rvc_direct", out_is_rvc, 1);
    chk("meta_bht_direct", out_bht, 2'b11);
    chk("meta_pred_direct", out_pred_pc, 32'h40);
    step();
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) offer(meta[i]);
    drain();

    // ---------------- 6: async reset mid-stall ----------------
    out_ready = 1'b0;
    offer(mk(32'h500, 32'h0000_0013, 32'h504, 2'b01, 1'b0, 1'b0));
    offer(mk(32'h504, 32'h0000_0013, 32'h508, 2'b01, 1'b0, 1'b0));
    chk("pre_rst_occ", occupancy, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready",  in_ready, 1);
    chk("arst_occ",       occupancy, 0);
    chk("arst_fcnt",      flush_count, 0);
    chk("arst_out_pc",    out_pc, 0);
    exp_q.delete();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    v = mk(32'h600, 32'h0050_0293, 32'h604, 2'b10, 1'b1, 1'b0);
    drive(v);
    in_valid = 1'b1;
    chk("post_rst_ready", in_ready, 1);
    exp_q.push_back(v);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_pc", out_pc, 32'h600);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
